// File: rtl/data_memory_responder_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes and FSM states.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package data_memory_responder_pkg;

  // RISC-V funct3 access-size/sign codes understood by the responder
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/data_memory_responder_lane_align.sv
// Byte-lane steering for loads and stores plus misaligned/unsupported detection.
// Latency: purely combinational.
// Backpressure: none; the parent decides when the result is used.
module dmem_lane_align
  import data_memory_responder_pkg::*;
(
  input  logic [2:0]  fun3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] mem_word,
  input  logic [31:0] writedata,
  output logic [31:0] load_val,
  output logic [3:0]  byte_en,
  output logic [31:0] store_word,
  output logic        bad
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = mem_word[{addr_lo, 3'b000} +: 8];
  assign sel_half = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];

  // Decode the access size: extend load data, build lane enables, replicate store data
  always_comb begin
    load_val   = '0;
    byte_en    = '0;
    store_word = writedata;
    bad        = 1'b0;
    case (fun3)
      F3_B: begin
        load_val   = {{24{sel_byte[7]}}, sel_byte};
        byte_en    = 4'b0001 << addr_lo;
        store_word = {4{writedata[7:0]}};
      end
      F3_BU: begin
        load_val = {24'h0, sel_byte};
        bad      = is_store;
      end
      F3_H: begin
        load_val   = {{16{sel_half[15]}}, sel_half};
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_word = {2{writedata[15:0]}};
        bad        = addr_lo[0];
      end
      F3_HU: begin
        load_val = {16'h0, sel_half};
        bad      = is_store | addr_lo[0];
      end
      F3_W: begin
        load_val = mem_word;
        byte_en  = 4'b1111;
        bad      = |addr_lo;
      end
      default: bad = 1'b1;
    endcase
    // A faulting access neither returns data nor touches any lane
    if (bad) begin
      load_val = '0;
      byte_en  = '0;
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: word-addressed storage behind an IDLE/BUSY/DONE handshake.
// Latency: busywait held LATENCY cycles from first sight of a request; result in the following DONE cycle.
// Backpressure: busywait stalls the initiator, which must hold its request stable until busywait drops.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int AW      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  input  logic [2:0]  fun3,
  output logic [31:0] readdata,
  output logic        busywait,
  output logic        error
);

  // The counter holds the number of BUSY cycles still to come after the current one,
  // so the IDLE cycle plus LATENCY-1 BUSY cycles give LATENCY stall cycles.
  localparam int             CW       = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0]  CNT_LOAD = CW'((LATENCY >= 2) ? LATENCY - 2 : 0);
  localparam bit             FAST     = (LATENCY == 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            op_wr_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [2:0]      fun3_q;

  logic [31:0]     mem [2**AW];

  logic            req;
  logic            live;
  logic            acc_wr;
  logic [AW+1:0]   acc_addr;
  logic [31:0]     acc_wdata;
  logic [2:0]      acc_fun3;
  logic            complete;
  logic            commit;
  logic [31:0]     load_val;
  logic [3:0]      byte_en;
  logic [31:0]     store_word;
  logic            bad;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^address[31:AW+2];

  assign req = read | write;

  // With LATENCY=1 the access completes straight out of IDLE, so it must see the live request
  assign live      = (state == IDLE);
  assign acc_wr    = live ? write              : op_wr_q;
  assign acc_addr  = live ? address[AW+1:0]    : addr_q;
  assign acc_wdata = live ? writedata          : wdata_q;
  assign acc_fun3  = live ? fun3               : fun3_q;

  assign complete = ((state == BUSY) && (cnt == '0)) || (FAST && (state == IDLE) && req);
  assign commit   = reset && complete && acc_wr && !bad;
  assign busywait = reset && (((state == IDLE) && req) || (state == BUSY));

  dmem_lane_align u_align (
    .fun3       (acc_fun3),
    .addr_lo    (acc_addr[1:0]),
    .is_store   (acc_wr),
    .mem_word   (mem[acc_addr[AW+1:2]]),
    .writedata  (acc_wdata),
    .load_val   (load_val),
    .byte_en    (byte_en),
    .store_word (store_word),
    .bad        (bad)
  );

  // Responder FSM: capture request, count down the latency, publish the result for one DONE cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      readdata <= '0;
      error    <= 1'b0;
      op_wr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      fun3_q   <= '0;
    end else begin
      error <= 1'b0;
      if (complete) begin
        state <= DONE;
        error <= bad;
        if (!acc_wr) readdata <= load_val;
      end else begin
        case (state)
          IDLE: if (req) begin
            op_wr_q <= write;
            addr_q  <= address[AW+1:0];
            wdata_q <= writedata;
            fun3_q  <= fun3;
            cnt     <= CNT_LOAD;
            state   <= BUSY;
          end
          BUSY:    cnt   <= cnt - CW'(1);
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Storage array: only enabled lanes of a clean, completing store are written
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (commit && byte_en[i]) mem[acc_addr[AW+1:2]][8*i +: 8] <= store_word[8*i +: 8];
    end
  end

endmodule
